// File: rtl/mips_main_control_pkg.sv
// Shared definitions for the MIPS main control decoder: opcodes, ALUOp
// encodings and the packed control bundle carried into the ID/EX latch.
package mips_main_control_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode decoder: maps the ID-stage opcode to the control bundle.
// Unlisted opcodes fall through to an all-zero bundle with illegal set.
module mips_ctrl_decode
  import mips_main_control_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (op_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        // RegDst/MemtoReg are don't-cares for stores; held at 0.
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// ID-stage main control: decodes the opcode and latches the controls into the
// ID/EX register, with Flush injecting a bubble and rst_n clearing asynchronously.
module mips_main_control
  import mips_main_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic               Flush,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Illegal
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  mips_ctrl_decode u_decode (
    .op_i   (Op),
    .ctrl_o (dec_ctrl)
  );

  // A flushed slot is a bubble: no write, no memory access, not illegal.
  always_comb begin
    ctrl_d = dec_ctrl;
    if (Flush) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ALUOp    = ctrl_q.alu_op;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed cases plus randomized
// opcodes/flushes checked against a table-driven reference of the decode.
module tb_mips_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       Flush;
  logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0] ALUOp;
  logic       Illegal;

  int checks;
  int errors;

  // Reference table: opcode -> {9 control bits as listed in the decode table}
  logic [8:0] ref_tbl [logic [5:0]];

  mips_main_control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Op       (Op),
    .Flush    (Flush),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] expect_out(input logic [5:0] op, input logic fl);
    if (fl) return 10'b0;
    if (ref_tbl.exists(op)) return {ref_tbl[op], 1'b0};
    return 10'b0000000001;
  endfunction

  function automatic logic [9:0] observed();
    return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal};
  endfunction

  task automatic step(input logic [5:0] op, input logic fl);
    @(negedge clk);
    Op = op;
    Flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] legal [5];
    logic [5:0] op;
    logic       fl;
    logic [9:0] exp_v;

    checks = 0;
    errors = 0;
    ref_tbl[6'b000000] = 9'b100100010;
    ref_tbl[6'b100011] = 9'b011110000;
    ref_tbl[6'b101011] = 9'b010001000;
    ref_tbl[6'b000100] = 9'b000000101;
    ref_tbl[6'b001000] = 9'b010100000;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};

    // Reset held: outputs stay zero across clock edges
    rst_n = 1'b0;
    Op    = 6'b100011;
    Flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'(observed()), 32'd0);

    // Release: first edge loads decode of current opcode
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_lw", 32'(observed()), 32'(10'b0111100000));
    $display("tx reset_release op=100011 out=%b", observed());

    // Each listed opcode, one per cycle
    for (int i = 0; i < 5; i++) begin
      step(legal[i], 1'b0);
      check($sformatf("seq_op_%b", legal[i]), 32'(observed()), 32'(expect_out(legal[i], 1'b0)));
      $display("tx seq op=%b out=%b", legal[i], observed());
    end

    // Illegal opcode then back to legal
    step(6'b111111, 1'b0);
    check("illegal_111111", 32'(observed()), 32'(10'b0000000001));
    $display("tx illegal op=111111 out=%b", observed());
    step(6'b000000, 1'b0);
    check("illegal_clear", 32'(Illegal), 32'd0);
    $display("tx legal op=000000 out=%b", observed());

    // Flush priority over decode, including over an illegal opcode
    step(6'b000000, 1'b1);
    check("flush_rtype", 32'(observed()), 32'd0);
    $display("tx flush op=000000 out=%b", observed());
    step(6'b000000, 1'b0);
    check("unflush_rtype", 32'(observed()), 32'(10'b1001000100));
    $display("tx unflush op=000000 out=%b", observed());
    step(6'b111110, 1'b1);
    check("flush_illegal", 32'(observed()), 32'd0);
    $display("tx flush op=111110 out=%b", observed());

    // Asynchronous clear mid-cycle
    step(6'b100011, 1'b0);
    check("pre_async_lw", 32'(observed()), 32'(10'b0111100000));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'(observed()), 32'd0);
    $display("tx async_reset out=%b", observed());
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized opcodes, mostly legal, occasional flush
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 4)];
      fl = ($urandom_range(0, 7) == 0);
      exp_v = expect_out(op, fl);
      step(op, fl);
      check("rand_ctrl", 32'(observed()), 32'(exp_v));
      check("rand_mem_excl", 32'(MemRead & MemWrite), 32'd0);
      check("rand_branch_nowr", 32'(Branch & RegWrite), 32'd0);
      $display("tx rand n=%0d op=%b flush=%b out=%b exp=%b", n, op, fl, observed(), exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
